// File: rtl/uart_rx_pkg.sv
// Shared types and helpers for the UART receive path.
//   rx_state_t : receiver FSM state encoding
//   div_calc   : clock-per-tick divisor for a given clock, baud and oversample
//   div_sel    : maps the 2-bit baud select code to a tick divisor
//   DIV_*      : divisor values at the default 100 MHz clock with 16x oversampling
package uart_rx_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        BREAK
    } rx_state_t;

    // Wide enough for the slowest rate (4800 baud at 100 MHz -> 1302)
    localparam int unsigned TICK_W = 11;

    localparam int unsigned BAUD_9600   = 9600;
    localparam int unsigned BAUD_4800   = 4800;
    localparam int unsigned BAUD_115200 = 115200;

    localparam int unsigned DEF_CLK_FREQ   = 100_000_000;
    localparam int unsigned DEF_OVERSAMPLE = 16;

    // Truncating divide; never returns zero so the tick counter always wraps
    function automatic logic [TICK_W-1:0] div_calc(input int unsigned clk_freq,
                                                   input int unsigned baud,
                                                   input int unsigned oversample);
        int unsigned q;
        q = clk_freq / (baud * oversample);
        if (q == 0) q = 1;
        return q[TICK_W-1:0];
    endfunction

    localparam logic [TICK_W-1:0] DIV_9600   = div_calc(DEF_CLK_FREQ, BAUD_9600,   DEF_OVERSAMPLE);
    localparam logic [TICK_W-1:0] DIV_4800   = div_calc(DEF_CLK_FREQ, BAUD_4800,   DEF_OVERSAMPLE);
    localparam logic [TICK_W-1:0] DIV_115200 = div_calc(DEF_CLK_FREQ, BAUD_115200, DEF_OVERSAMPLE);
    // Simulation mode: one tick per clock, independent of clock frequency
    localparam logic [TICK_W-1:0] DIV_SIM    = 11'd1;

    function automatic logic [TICK_W-1:0] div_sel(input logic [1:0]  s,
                                                  input int unsigned clk_freq,
                                                  input int unsigned oversample);
        logic [TICK_W-1:0] d;
        case (s)
            2'b00:   d = div_calc(clk_freq, BAUD_9600,   oversample);
            2'b01:   d = div_calc(clk_freq, BAUD_4800,   oversample);
            2'b10:   d = div_calc(clk_freq, BAUD_115200, oversample);
            default: d = DIV_SIM;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/baud_tick_gen.sv
// Oversampling tick generator.
//   clk_in : system clock
//   reset  : asynchronous active-high reset
//   div    : clocks per tick (>= 1)
//   clear  : restart the count from zero (aligns ticks to a frame)
//   tick   : one-cycle strobe every div clocks
module baud_tick_gen
    import uart_rx_pkg::*;
(
    input  logic              clk_in,
    input  logic              reset,
    input  logic [TICK_W-1:0] div,
    input  logic              clear,
    output logic              tick
);

    logic [TICK_W-1:0] cnt;

    // ">=" rather than "==" so a divisor that shrinks under a running count
    // still wraps instead of running all the way round the counter.
    assign tick = (cnt >= (div - 11'd1));

    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (clear || tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 11'd1;
        end
    end

endmodule

// File: rtl/uart_receiver.sv
// UART receiver, 8N1, LSB first, 16x oversampled.
//   clk_in      : system clock
//   reset       : asynchronous active-high reset
//   S           : baud select 00=9600 01=4800 10=115200 11=one tick per clock
//   rx          : asynchronous serial input, idle high
//   rx_data     : last received byte
//   rx_valid    : byte available, held until rx_valid && rx_ready
//   rx_ready    : consumer accept
//   frame_err   : one-cycle pulse, stop bit sampled low
//   overrun_err : one-cycle pulse, byte completed while previous one unread
//   busy        : receiver is not idle
module uart_receiver
    import uart_rx_pkg::*;
#(
    parameter int unsigned CLK_FREQ   = 100_000_000,
    parameter int unsigned OVERSAMPLE = 16,
    parameter int unsigned DATA_BITS  = 8
) (
    input  logic                 clk_in,
    input  logic                 reset,
    input  logic [1:0]           S,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 frame_err,
    output logic                 overrun_err,
    output logic                 busy
);

    localparam logic [3:0] SAMPLE_MID  = 4'(OVERSAMPLE / 2 - 1);
    localparam logic [3:0] SAMPLE_LAST = 4'(OVERSAMPLE - 1);
    localparam logic [2:0] BIT_LAST    = 3'(DATA_BITS - 1);

    logic                 rx_m, rx_s, rx_prev;
    logic [TICK_W-1:0]    div_q;
    logic                 tick;
    rx_state_t            state, state_n;
    logic [3:0]           sample_cnt;
    logic [2:0]           bit_cnt;
    logic [DATA_BITS-1:0] shift_q;

    // Decoded strobes from the next-state logic
    logic start_det, go_data, shift_en, stop_good, stop_bad;

    // Two-flop synchroniser plus one history flop for falling-edge detection
    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            rx_m    <= 1'b1;
            rx_s    <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_m    <= rx;
            rx_s    <= rx_m;
            rx_prev <= rx_s;
        end
    end

    // Rate only follows S between frames so a mid-frame change cannot
    // corrupt the byte in flight.
    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            div_q <= DIV_SIM;
        end else if (state == IDLE) begin
            div_q <= div_sel(S, CLK_FREQ, OVERSAMPLE);
        end
    end

    baud_tick_gen u_tick (
        .clk_in (clk_in),
        .reset  (reset),
        .div    (div_q),
        .clear  (start_det),
        .tick   (tick)
    );

    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n   = state;
        start_det = 1'b0;
        go_data   = 1'b0;
        shift_en  = 1'b0;
        stop_good = 1'b0;
        stop_bad  = 1'b0;
        case (state)
            IDLE: begin
                if (rx_prev && !rx_s) begin
                    state_n   = START;
                    start_det = 1'b1;
                end
            end
            START: begin
                // Re-check mid start bit; a line already back high was a glitch
                if (tick && sample_cnt == SAMPLE_MID) begin
                    if (rx_s) begin
                        state_n = IDLE;
                    end else begin
                        state_n = DATA;
                        go_data = 1'b1;
                    end
                end
            end
            DATA: begin
                if (tick && sample_cnt == SAMPLE_LAST) begin
                    shift_en = 1'b1;
                    if (bit_cnt == BIT_LAST) state_n = STOP;
                end
            end
            STOP: begin
                if (tick && sample_cnt == SAMPLE_LAST) begin
                    if (rx_s) begin
                        stop_good = 1'b1;
                        state_n   = IDLE;
                    end else begin
                        stop_bad = 1'b1;
                        state_n  = BREAK;
                    end
                end
            end
            BREAK: begin
                // Hold off until the line idles so a stuck-low line cannot retrigger
                if (rx_s) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    // Counters and shift register. Starting in mid start bit, a full bit
    // period of ticks lands each later sample in the middle of its bit.
    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            sample_cnt <= '0;
            bit_cnt    <= '0;
            shift_q    <= '0;
        end else begin
            if (start_det || go_data) begin
                sample_cnt <= '0;
            end else if (tick) begin
                sample_cnt <= sample_cnt + 4'd1;
            end

            if (start_det) begin
                bit_cnt <= '0;
            end else if (shift_en) begin
                bit_cnt <= bit_cnt + 3'd1;
            end

            // LSB arrives first, so shift in at the top
            if (shift_en) begin
                shift_q <= {rx_s, shift_q[DATA_BITS-1:1]};
            end
        end
    end

    // Output handshake. A completing byte wins over an accept in the same
    // cycle, and only counts as an overrun when nobody is taking the old one.
    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            rx_data     <= '0;
            rx_valid    <= 1'b0;
            frame_err   <= 1'b0;
            overrun_err <= 1'b0;
        end else begin
            frame_err   <= stop_bad;
            overrun_err <= stop_good && rx_valid && !rx_ready;
            if (stop_good) begin
                rx_data  <= shift_q;
                rx_valid <= 1'b1;
            end else if (rx_valid && rx_ready) begin
                rx_valid <= 1'b0;
            end
        end
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_uart_receiver.sv
// Directed bench for uart_receiver: reset state, single and back-to-back
// frames, framing error with held-low line, start-bit glitch, overrun, and a
// slow-rate frame with a mid-frame rate change followed by a mid-frame reset.
module tb_uart_receiver;

    logic       clk_in = 1'b0;
    logic       reset;
    logic [1:0] S;
    logic       rx;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;
    logic       frame_err;
    logic       overrun_err;
    logic       busy;

    int checks   = 0;
    int failures = 0;

    uart_receiver #(
        .CLK_FREQ   (100_000_000),
        .OVERSAMPLE (16),
        .DATA_BITS  (8)
    ) dut (
        .clk_in      (clk_in),
        .reset       (reset),
        .S           (S),
        .rx          (rx),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .rx_ready    (rx_ready),
        .frame_err   (frame_err),
        .overrun_err (overrun_err),
        .busy        (busy)
    );

    always #5 clk_in = ~clk_in;

    int cyc = 0;
    always @(posedge clk_in) cyc <= cyc + 1;

    // Event recorders, sampled on the falling edge
    logic       frame_d = 1'b0, ovr_d = 1'b0, busy_d = 1'b0, valid_d = 1'b0;
    int         frame_pulses = 0, frame_hi = 0;
    int         ovr_pulses = 0, ovr_hi = 0;
    int         busy_rises = 0;
    int         rise_cyc = 0;
    logic [7:0] acc_q[$];

    always @(negedge clk_in) begin
        frame_d <= frame_err;
        ovr_d   <= overrun_err;
        busy_d  <= busy;
        valid_d <= rx_valid;
        if (frame_err)                frame_hi     <= frame_hi + 1;
        if (frame_err && !frame_d)    frame_pulses <= frame_pulses + 1;
        if (overrun_err)              ovr_hi       <= ovr_hi + 1;
        if (overrun_err && !ovr_d)    ovr_pulses   <= ovr_pulses + 1;
        if (busy && !busy_d)          busy_rises   <= busy_rises + 1;
        if (rx_valid && !valid_d)     rise_cyc     <= cyc;
        if (rx_valid && rx_ready)     acc_q.push_back(rx_data);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk_in);
    endtask

    task automatic drive_bits(input logic [7:0] d, input int first, input int last,
                              input int bit_clks);
        for (int i = first; i <= last; i++) begin
            rx = d[i];
            idle(bit_clks);
        end
    endtask

    task automatic drive_frame(input logic [7:0] d, input logic stop_lvl,
                               input int bit_clks, output int t_start);
        t_start = cyc;
        rx = 1'b0;
        idle(bit_clks);
        drive_bits(d, 0, 7, bit_clks);
        rx = stop_lvl;
        idle(bit_clks);
    endtask

    int t0;
    int base_f, base_fh, base_o, base_oh, base_b, base_q;

    initial begin
        rx       = 1'b1;
        rx_ready = 1'b0;
        S        = 2'b11;
        reset    = 1'b1;
        idle(4);

        chk("rst_rx_valid",  32'(rx_valid),    32'd0);
        chk("rst_rx_data",   32'(rx_data),     32'h00);
        chk("rst_frame_err", 32'(frame_err),   32'd0);
        chk("rst_overrun",   32'(overrun_err), 32'd0);
        chk("rst_busy",      32'(busy),        32'd0);

        reset = 1'b0;
        idle(4);
        chk("idle_busy", 32'(busy), 32'd0);

        // Single byte 0xA5, sim rate (16 clk/bit)
        drive_frame(8'hA5, 1'b1, 16, t0);
        idle(2);
        chk("a5_valid",   32'(rx_valid),       32'd1);
        chk("a5_data",    32'(rx_data),        32'hA5);
        chk("a5_latency", 32'(rise_cyc - t0),  32'd155);
        chk("a5_frame",   32'(frame_pulses),   32'd0);
        chk("a5_busy",    32'(busy),           32'd0);
        rx_ready = 1'b1;
        idle(1);
        chk("a5_accept_clears", 32'(rx_valid), 32'd0);

        // Back-to-back 0x3C, 0xC3 with consumer always ready
        idle(2);
        acc_q.delete();
        drive_frame(8'h3C, 1'b1, 16, t0);
        drive_frame(8'hC3, 1'b1, 16, t0);
        idle(4);
        chk("b2b_count",  32'(acc_q.size()), 32'd2);
        chk("b2b_first",  32'(acc_q[0]),     32'h3C);
        chk("b2b_second", 32'(acc_q[1]),     32'hC3);
        chk("b2b_errs",   32'(frame_pulses + ovr_pulses), 32'd0);
        chk("b2b_valid",  32'(rx_valid),     32'd0);

        // 0x55 with stop bit low and line held low for 40 clocks
        base_f  = frame_pulses;
        base_fh = frame_hi;
        base_q  = acc_q.size();
        drive_frame(8'h55, 1'b0, 16, t0);
        idle(24);
        chk("ferr_pulses",   32'(frame_pulses - base_f), 32'd1);
        chk("ferr_width",    32'(frame_hi - base_fh),    32'd1);
        chk("ferr_valid",    32'(rx_valid),              32'd0);
        chk("ferr_no_data",  32'(acc_q.size() - base_q), 32'd0);
        chk("ferr_held_busy", 32'(busy),                 32'd1);
        rx = 1'b1;
        idle(5);
        chk("ferr_release_busy", 32'(busy),     32'd0);
        chk("ferr_release_valid", 32'(rx_valid), 32'd0);

        // 4-clock low glitch while idle
        base_b = busy_rises;
        base_f = frame_pulses;
        rx = 1'b0;
        idle(4);
        rx = 1'b1;
        idle(20);
        chk("glitch_busy_pulsed", 32'(busy_rises - base_b), 32'd1);
        chk("glitch_busy_idle",   32'(busy),                32'd0);
        chk("glitch_valid",       32'(rx_valid),            32'd0);
        chk("glitch_no_ferr",     32'(frame_pulses - base_f), 32'd0);

        // Overrun: 0x11 then 0x22 with consumer stalled
        rx_ready = 1'b0;
        base_o  = ovr_pulses;
        base_oh = ovr_hi;
        base_f  = frame_pulses;
        drive_frame(8'h11, 1'b1, 16, t0);
        drive_frame(8'h22, 1'b1, 16, t0);
        idle(4);
        chk("ovr_valid",   32'(rx_valid),            32'd1);
        chk("ovr_data",    32'(rx_data),             32'h22);
        chk("ovr_pulses",  32'(ovr_pulses - base_o), 32'd1);
        chk("ovr_width",   32'(ovr_hi - base_oh),    32'd1);
        chk("ovr_no_ferr", 32'(frame_pulses - base_f), 32'd0);
        rx_ready = 1'b1;
        idle(1);
        chk("ovr_accept_clears", 32'(rx_valid), 32'd0);
        rx_ready = 1'b0;

        // 115200 (864 clk/bit) byte 0xF0, S changed to 9600 mid-frame
        S = 2'b10;
        idle(5);
        base_o = ovr_pulses;
        base_f = frame_pulses;
        rx = 1'b0;
        idle(864);
        drive_bits(8'hF0, 0, 2, 864);
        S = 2'b00;
        drive_bits(8'hF0, 3, 7, 864);
        rx = 1'b1;
        idle(864);
        idle(4);
        chk("slow_valid", 32'(rx_valid),              32'd1);
        chk("slow_data",  32'(rx_data),               32'hF0);
        chk("slow_errs",  32'((frame_pulses - base_f) + (ovr_pulses - base_o)), 32'd0);

        // Second frame at 9600, aborted by reset during its start bit
        rx = 1'b0;
        idle(2000);
        chk("abort_busy_before", 32'(busy), 32'd1);
        reset = 1'b1;
        idle(1);
        rx = 1'b1;
        chk("abort_rx_valid",  32'(rx_valid),    32'd0);
        chk("abort_rx_data",   32'(rx_data),     32'h00);
        chk("abort_busy",      32'(busy),        32'd0);
        chk("abort_frame_err", 32'(frame_err),   32'd0);
        chk("abort_overrun",   32'(overrun_err), 32'd0);
        idle(3);
        reset = 1'b0;
        S = 2'b11;
        idle(5);

        // Next frame at the newly selected rate
        base_f = frame_pulses;
        drive_frame(8'h96, 1'b1, 16, t0);
        idle(4);
        chk("post_rst_valid", 32'(rx_valid),              32'd1);
        chk("post_rst_data",  32'(rx_data),               32'h96);
        chk("post_rst_ferr",  32'(frame_pulses - base_f), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
